// File: rtl/pipe_ctrl_pkg.sv
// Shared processor defines for the pipeline controller: register-address
// width, controller state encoding and the pipeline control bundle.
package pipe_ctrl_pkg;

  localparam int REG_AW       = 3;
  localparam int DRAIN_CYCLES = 4;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_IDLE   = pipe_ctl_t'(7'b00000_00);
  localparam pipe_ctl_t CTL_NORMAL = pipe_ctl_t'(7'b11111_00);
  localparam pipe_ctl_t CTL_BRANCH = pipe_ctl_t'(7'b11111_11);
  // idex_en stays high on a load-use bubble; the flush wins anyway
  localparam pipe_ctl_t CTL_LDUSE  = pipe_ctl_t'(7'b00111_01);
  localparam pipe_ctl_t CTL_DRAIN  = pipe_ctl_t'(7'b01111_10);

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the instruction in ID and a load in EX.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_wreg,
  output logic              load_use
);

  assign load_use = ex_memread &
                    ((id_use_rs1 & (id_rs1 == ex_wreg)) |
                     (id_use_rs2 & (id_rs2 == ex_wreg)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/halt controller: RUN/DRAIN/HALTED sequencing,
// memory-wait timeout and stall-cycle accounting.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_wreg,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              mem_ack,
  input  logic              host_halt_req,
  input  logic              stall_clr,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              halt_ack,
  output logic              mem_timeout,
  output logic [31:0]       stall_cnt
);

  logic [1:0]  state_q, state_d;
  logic [2:0]  drain_q, drain_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        timeout_q, timeout_d;

  logic        mem_stall, load_use, stall_cyc, lu_cyc, drain_adv;
  pipe_ctl_t   ctl;

  hazard_detect u_hazard (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_memread (ex_memread),
    .ex_wreg    (ex_wreg),
    .load_use   (load_use)
  );

  assign mem_stall = mem_req & ~mem_ack;
  assign stall_cyc = (state_q != ST_HALTED) & mem_stall;
  assign lu_cyc    = (state_q != ST_HALTED) & ~mem_stall & ~branch_taken & load_use;

  always_comb begin
    ctl       = CTL_IDLE;
    state_d   = state_q;
    drain_d   = drain_q;
    drain_adv = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!mem_stall) begin
          if (branch_taken)  ctl = CTL_BRANCH;
          else if (load_use) ctl = CTL_LDUSE;
          else begin
            ctl = CTL_NORMAL;
            if (host_halt_req) begin
              state_d = ST_DRAIN;
              drain_d = 3'd0;
            end
          end
        end
      end
      ST_DRAIN: begin
        // host_halt_req is ignored here: once started, a drain always completes
        if (!mem_stall) begin
          if (branch_taken) begin
            ctl       = CTL_BRANCH;
            drain_adv = 1'b1;
          end else if (load_use) begin
            ctl = CTL_LDUSE;
          end else begin
            ctl       = CTL_DRAIN;
            drain_adv = 1'b1;
          end
        end
        if (drain_adv) begin
          if (drain_q == 3'(DRAIN_CYCLES - 1)) begin
            state_d = ST_HALTED;
            drain_d = 3'd0;
          end else begin
            drain_d = drain_q + 3'd1;
          end
        end
      end
      ST_HALTED: begin
        if (!host_halt_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    wait_d = 8'd0;
    if (stall_cyc) wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
    timeout_d = timeout_q | (stall_cyc & (wait_d == 8'(MEM_TIMEOUT)));
    stall_cnt_d = stall_cnt_q;
    if (stall_clr)                                       stall_cnt_d = 32'd0;
    else if ((stall_cyc | lu_cyc) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      drain_q     <= 3'd0;
      wait_q      <= 8'd0;
      stall_cnt_q <= 32'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Decode is combinational, so gate it with reset to keep enables low while held
  assign pc_en       = ctl.pc_en      & reset;
  assign ifid_en     = ctl.ifid_en    & reset;
  assign idex_en     = ctl.idex_en    & reset;
  assign exmem_en    = ctl.exmem_en   & reset;
  assign memwb_en    = ctl.memwb_en   & reset;
  assign ifid_flush  = ctl.ifid_flush & reset;
  assign idex_flush  = ctl.idex_flush & reset;
  assign halt_ack    = (state_q == ST_HALTED);
  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazards, memory stalls, timeout, drain/halt, reset.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] id_rs1, id_rs2, ex_wreg;
  logic id_use_rs1, id_use_rs2, ex_memread, branch_taken;
  logic mem_req, mem_ack, host_halt_req, stall_clr;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
  logic halt_ack, mem_timeout;
  logic [31:0] stall_cnt;

  logic pc_en_t, ifid_en_t, idex_en_t, exmem_en_t, memwb_en_t, ifid_flush_t, idex_flush_t;
  logic halt_ack_t, mem_timeout_t;
  logic [31:0] stall_cnt_t;

  logic [6:0] vec;
  assign vec = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};

  localparam logic [6:0] V_ZERO = 7'b00000_00;
  localparam logic [6:0] V_NORM = 7'b11111_00;
  localparam logic [6:0] V_BR   = 7'b11111_11;
  localparam logic [6:0] V_LU   = 7'b00111_01;
  localparam logic [6:0] V_DRN  = 7'b01111_10;

  int checks = 0;
  int failures = 0;

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread),
    .ex_wreg(ex_wreg), .branch_taken(branch_taken), .mem_req(mem_req),
    .mem_ack(mem_ack), .host_halt_req(host_halt_req), .stall_clr(stall_clr),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .halt_ack(halt_ack), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  pipe_ctrl #(.MEM_TIMEOUT(4)) dut_t (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread),
    .ex_wreg(ex_wreg), .branch_taken(branch_taken), .mem_req(mem_req),
    .mem_ack(mem_ack), .host_halt_req(host_halt_req), .stall_clr(stall_clr),
    .pc_en(pc_en_t), .ifid_en(ifid_en_t), .idex_en(idex_en_t), .exmem_en(exmem_en_t),
    .memwb_en(memwb_en_t), .ifid_flush(ifid_flush_t), .idex_flush(idex_flush_t),
    .halt_ack(halt_ack_t), .mem_timeout(mem_timeout_t), .stall_cnt(stall_cnt_t)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    id_rs1 = 3'd0; id_rs2 = 3'd0; ex_wreg = 3'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memread = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0; stall_clr = 1'b0;
  endtask

  initial begin
    idle_in();
    host_halt_req = 1'b0;
    #1 reset = 1'b0;
    tick(); tick();
    chk("rst_vec", 32'(vec), 32'(V_ZERO));
    chk("rst_halt_ack", 32'(halt_ack), 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_timeout", 32'(mem_timeout_t), 32'd0);
    #2 reset = 1'b1;

    tick(); idle_in(); #1;
    chk("run_normal", 32'(vec), 32'(V_NORM));

    // load r3 in EX, ID reads rs1=r3
    tick(); ex_memread = 1'b1; ex_wreg = 3'd3; id_rs1 = 3'd3; id_use_rs1 = 1'b1; #1;
    chk("lu_rs1", 32'(vec), 32'(V_LU));
    tick(); idle_in(); #1;
    chk("lu_one_cycle", 32'(vec), 32'(V_NORM));
    chk("lu_stall_cnt", stall_cnt, 32'd1);

    tick(); ex_memread = 1'b1; ex_wreg = 3'd5; id_rs1 = 3'd2; id_use_rs1 = 1'b1;
    id_rs2 = 3'd5; id_use_rs2 = 1'b1; #1;
    chk("lu_rs2", 32'(vec), 32'(V_LU));
    tick(); ex_memread = 1'b1; ex_wreg = 3'd3; id_rs1 = 3'd3; id_use_rs1 = 1'b0;
    id_rs2 = 3'd3; id_use_rs2 = 1'b0; #1;
    chk("lu_not_used", 32'(vec), 32'(V_NORM));
    chk("lu2_stall_cnt", stall_cnt, 32'd2);
    tick(); ex_memread = 1'b0; id_use_rs1 = 1'b1; #1;
    chk("lu_not_load", 32'(vec), 32'(V_NORM));

    tick(); idle_in(); stall_clr = 1'b1; #1;
    chk("clr_cycle_vec", 32'(vec), 32'(V_NORM));

    // 6-cycle memory wait: MEM_TIMEOUT=4 instance flags, default does not
    tick(); stall_clr = 1'b0; mem_req = 1'b1; #1;
    chk("clr_stall_cnt", stall_cnt, 32'd0);
    chk("mw_stall_1", 32'(vec), 32'(V_ZERO));
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      chk("mw_stall_n", 32'(vec), 32'(V_ZERO));
      if (i == 1) chk("timeout_early", 32'(mem_timeout_t), 32'd0);
      if (i == 3) chk("timeout_set", 32'(mem_timeout_t), 32'd1);
    end
    chk("timeout_default_clear", 32'(mem_timeout), 32'd0);
    tick(); mem_ack = 1'b1; stall_clr = 1'b1; #1;
    chk("mw_ack_vec", 32'(vec), 32'(V_NORM));
    chk("mw_stall_cnt6", stall_cnt, 32'd6);

    // 5-cycle memory wait
    tick(); stall_clr = 1'b0; mem_ack = 1'b0; #1;
    chk("m5_clr", stall_cnt, 32'd0);
    chk("m5_stall", 32'(vec), 32'(V_ZERO));
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      chk("m5_stall_n", 32'(vec), 32'(V_ZERO));
    end
    tick(); mem_ack = 1'b1; #1;
    chk("m5_ack_vec", 32'(vec), 32'(V_NORM));
    tick(); idle_in(); #1;
    chk("m5_stall_cnt", stall_cnt, 32'd5);
    chk("m5_timeout", 32'(mem_timeout), 32'd0);
    chk("timeout_sticky", 32'(mem_timeout_t), 32'd1);

    // branch wins over load-use
    tick(); branch_taken = 1'b1; ex_memread = 1'b1; ex_wreg = 3'd4;
    id_rs1 = 3'd4; id_use_rs1 = 1'b1; #1;
    chk("br_over_lu", 32'(vec), 32'(V_BR));
    tick(); idle_in(); #1;
    chk("br_stall_cnt", stall_cnt, 32'd5);
    chk("br_after", 32'(vec), 32'(V_NORM));

    // drain with one memory stall, halt_ack six cycles after the request
    tick(); host_halt_req = 1'b1; #1;
    chk("halt_req_cycle", 32'(vec), 32'(V_NORM));
    chk("halt_ack_c0", 32'(halt_ack), 32'd0);
    tick(); #1;
    chk("drain_1", 32'(vec), 32'(V_DRN));
    tick(); mem_req = 1'b1; #1;
    chk("drain_stall", 32'(vec), 32'(V_ZERO));
    tick(); mem_req = 1'b0; #1;
    chk("drain_2", 32'(vec), 32'(V_DRN));
    tick(); host_halt_req = 1'b0; #1;
    chk("drain_3_noabort", 32'(vec), 32'(V_DRN));
    tick(); #1;
    chk("drain_4", 32'(vec), 32'(V_DRN));
    chk("halt_ack_c5", 32'(halt_ack), 32'd0);
    tick(); host_halt_req = 1'b1; #1;
    chk("halt_ack_c6", 32'(halt_ack), 32'd1);
    chk("halted_vec", 32'(vec), 32'(V_ZERO));
    chk("halted_stall_cnt", stall_cnt, 32'd6);
    tick(); host_halt_req = 1'b0; #1;
    chk("halt_hold", 32'(halt_ack), 32'd1);
    tick(); #1;
    chk("release_ack", 32'(halt_ack), 32'd0);
    chk("release_vec", 32'(vec), 32'(V_NORM));

    // reset in the middle of a drain
    tick(); host_halt_req = 1'b1; #1;
    chk("rd_req", 32'(vec), 32'(V_NORM));
    tick(); host_halt_req = 1'b0; #1;
    chk("rd_drain", 32'(vec), 32'(V_DRN));
    #1 reset = 1'b0;
    #1;
    chk("rd_rst_vec", 32'(vec), 32'(V_ZERO));
    chk("rd_rst_ack", 32'(halt_ack), 32'd0);
    chk("rd_rst_cnt", stall_cnt, 32'd0);
    chk("rd_rst_timeout", 32'(mem_timeout_t), 32'd0);
    #2 reset = 1'b1;
    tick(); #1;
    chk("rd_rel_pc_en", 32'(pc_en), 32'd1);
    chk("rd_rel_vec", 32'(vec), 32'(V_NORM));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and reset.
REQ-002 Parameter MEM_TIMEOUT, default 64, SHALL set the consecutive memory-wait cycles (1..255) after which mem_timeout is flagged.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  asynchronous active-low reset.
REQ-005 id_rs1, id_rs2  in  3 each  source register addresses of the instruction in ID.
REQ-006 id_use_rs1, id_use_rs2  in  1 each  ID instruction reads rs1 / rs2.
REQ-007 ex_memread, ex_wreg  in  1, 3  EX instruction is a load, and its destination register.
REQ-008 branch_taken  in  1  EX resolved a taken branch this cycle.
REQ-009 mem_req, mem_ack  in  1 each  data-memory access pending in MEM, and access complete.
REQ-010 host_halt_req, stall_clr  in  1 each  host halt request (level), and synchronous clear of stall_cnt.
REQ-011 pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  PC and pipe-register load enables.
REQ-012 ifid_flush, idex_flush  out  1 each  synchronous bubble insert into IF/ID and ID/EX; flush overrides en.
REQ-013 halt_ack, mem_timeout, stall_cnt  out  1, 1, 32  pipeline halted, sticky timeout flag, stall-cycle counter.

Function
REQ-014 The block SHALL have states RUN, DRAIN and HALTED; all enable and flush outputs SHALL be combinational from state and the current inputs.
REQ-015 mem_stall = mem_req & ~mem_ack SHALL have the highest priority, in every state except HALTED: all en=0, pc_en=0, flushes=0.
REQ-016 Load-use hazard SHALL be detected as ex_memread & ((id_use_rs1 & id_rs1==ex_wreg) | (id_use_rs2 & id_rs2==ex_wreg)).
REQ-017 In RUN, priority after mem_stall SHALL be: branch_taken, then load-use, then normal.
REQ-018 Branch response SHALL be pc_en=1, all en=1, ifid_flush=1, idex_flush=1 (two bubbles).
REQ-019 Load-use response SHALL be pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1, for exactly one cycle per hazard.
REQ-020 Normal response SHALL be pc_en=1, all en=1, flushes=0.
REQ-021 RUN->DRAIN SHALL occur only on a normal cycle with host_halt_req=1; that cycle SHALL still output the normal response.
REQ-022 In DRAIN, normal cycles SHALL output pc_en=0, ifid_flush=1, other en=1; a 3-bit drain counter SHALL advance on each of these cycles.
REQ-023 In DRAIN, branch SHALL output as REQ-018 (PC latches the target) and advance the drain counter; load-use SHALL output as REQ-019 and hold the counter; mem_stall SHALL hold the counter.
REQ-024 After 4 counted drain cycles the block SHALL enter HALTED; host_halt_req deassertion during DRAIN SHALL NOT abort the drain.
REQ-025 In HALTED, all en=0, pc_en=0, flushes=0 and halt_ack=1; host_halt_req=0 SHALL return the block to RUN on the next edge.
REQ-026 An 8-bit wait counter SHALL increment on each mem_stall cycle and clear on any cycle without mem_stall.
REQ-027 When the wait counter reaches MEM_TIMEOUT, mem_timeout SHALL set and stay set until reset; the stall itself SHALL continue.
REQ-028 stall_cnt SHALL increment on every mem_stall or load-use cycle and saturate at 0xFFFFFFFF; stall_clr SHALL clear it and take priority over the increment.

Reset
REQ-029 While reset=0: state=RUN, drain counter=0, wait counter=0, stall_cnt=0, mem_timeout=0, halt_ack=0, all en/pc_en=0, flushes=0.
REQ-030 Reset assertion mid-DRAIN or mid-mem_stall SHALL abandon the operation; the first cycle after release SHALL be a RUN cycle.

Structure
REQ-031 The state encoding and the 3-bit register-address width SHALL live in the shared processor defines file.
REQ-032 Load-use comparison SHALL be a combinational sub-module named hazard_detect; the FSM, counters and output decode SHALL be in pipe_ctrl.

Verification
REQ-033 Load r3 in EX (ex_wreg=3), ID uses rs1=3 -> 1 cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1.
REQ-034 mem_req=1, mem_ack=0 for 5 cycles, then ack -> all en=0 for 5 cycles; stall_cnt=5; mem_timeout=0.
REQ-035 MEM_TIMEOUT=4, mem_ack held 0 for 6 cycles -> mem_timeout=1 from the 4th wait cycle and sticky after ack.
REQ-036 branch_taken=1 and load-use in the same cycle -> branch response only; stall_cnt unchanged.
REQ-037 host_halt_req=1 at a normal cycle, one mem_stall cycle during drain -> halt_ack=1 exactly 6 cycles later; release -> RUN next cycle.
REQ-038 reset=0 during DRAIN -> outputs match REQ-029 immediately; after release, pc_en=1 with host_halt_req=0.
